// File: rtl/tl_axi_rd_splitter_pkg.sv
// Shared types and helpers for the AXI AR to PCIe MemRd splitter.
// Provides TLP fmt/type constants, the memory request header layout,
// the MRRS decode and the header packing helper.
package tl_axi_rd_splitter_pkg;

    localparam int unsigned HDR_W        = 128;
    localparam int unsigned CHUNK_W      = 14;  // bytes, holds up to 8192
    localparam int unsigned MRRS_MIN_LG2 = 7;   // code 0 = 128 B

    localparam logic [2:0] FMT_3DW_NODATA = 3'b000;
    localparam logic [2:0] FMT_4DW_NODATA = 3'b001;
    localparam logic [4:0] TYPE_MEM       = 5'b00000;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SPLIT = 1'b1
    } rd_state_e;

    // Memory request header, DW0 in the top 32 bits. Address DWs are stored
    // byte-swapped (package byte order) so the wire sees PCIe big-endian bytes.
    typedef struct packed {
        // DW0
        logic [2:0]  fmt;
        logic [4:0]  tlp_type;
        logic        tg_h;
        logic [2:0]  tc;
        logic        tg_m;
        logic        attr2;
        logic        ln;
        logic        th;
        logic        td;
        logic        ep;
        logic [1:0]  attr;
        logic [1:0]  at;
        logic [9:0]  length;
        // DW1
        logic [15:0] requester_id;
        logic [7:0]  tag;
        logic [7:0]  byte_enable;
        // DW2 / DW3
        logic [31:0] addr_h;
        logic [31:0] addr_l;
    } tlp_memory_req_hdr_t;

    function automatic logic [31:0] swap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    // MRRS code to bytes, clamped to the largest legal size.
    function automatic logic [CHUNK_W-1:0] mrrs_decode(input logic [2:0] code,
                                                      input int unsigned max_lg2);
        logic [2:0] lim;
        logic [2:0] c;
        lim = 3'(max_lg2 - MRRS_MIN_LG2);
        c   = (code > lim) ? lim : code;
        return 14'd128 << c;
    endfunction

    // Build a MemRd header; 3DW whenever the upper address DW is zero.
    function automatic tlp_memory_req_hdr_t pack_mem_rd_hdr(input logic [63:0] addr,
                                                            input logic [9:0]  len,
                                                            input logic [7:0]  tag,
                                                            input logic [15:0] rid);
        tlp_memory_req_hdr_t h;
        h              = '0;
        h.tlp_type     = TYPE_MEM;
        h.length       = len;
        h.requester_id = rid;
        h.tag          = tag;
        h.byte_enable  = 8'hFF;
        if (addr[63:32] == 32'h0) begin
            h.fmt    = FMT_3DW_NODATA;
            h.addr_h = swap32({addr[31:2], 2'b00});
            h.addr_l = 32'h0;
        end else begin
            h.fmt    = FMT_4DW_NODATA;
            h.addr_h = swap32(addr[63:32]);
            h.addr_l = swap32({addr[31:2], 2'b00});
        end
        return h;
    endfunction

endpackage

// File: rtl/tl_axi_rd_splitter_tag_alloc.sv
// Tag pool: busy bitmap, lowest-free priority encoder, outstanding count,
// sticky invalid-free flag and a per-tag {id, last} table with comb lookup.
// Ports: alloc/alloc_id/alloc_last (allocate), free/free_tag (release),
// lookup_tag -> lookup_id_c/lookup_last_c, free_avail_c/alloc_tag_c (pool
// status), outstanding, err (registered).
module tl_tag_alloc #(
    parameter  int unsigned NUM_TAGS = 64,
    parameter  int unsigned ID_W     = 4,
    localparam int unsigned TAG_BIT  = $clog2(NUM_TAGS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               alloc,
    input  logic [ID_W-1:0]    alloc_id,
    input  logic               alloc_last,
    output logic               free_avail_c,
    output logic [TAG_BIT-1:0] alloc_tag_c,
    input  logic               free,
    input  logic [TAG_BIT-1:0] free_tag,
    input  logic [TAG_BIT-1:0] lookup_tag,
    output logic [ID_W-1:0]    lookup_id_c,
    output logic               lookup_last_c,
    output logic [TAG_BIT:0]   outstanding,
    output logic               err
);

    localparam int unsigned CNT_W = TAG_BIT + 1;

    logic [NUM_TAGS-1:0] busy_q;
    logic [NUM_TAGS-1:0] busy_nxt;
    logic [ID_W-1:0]     id_tab [NUM_TAGS];
    logic [NUM_TAGS-1:0] last_tab;
    logic                alloc_ok;
    logic                free_ok;

    assign free_avail_c = ~&busy_q;
    assign alloc_ok     = alloc & free_avail_c;
    assign free_ok      = free & busy_q[free_tag];

    // Lowest-index free tag from the bitmap as it stood at cycle start.
    always_comb begin
        alloc_tag_c = '0;
        for (int i = int'(NUM_TAGS) - 1; i >= 0; i--) begin
            if (!busy_q[i]) alloc_tag_c = TAG_BIT'(i);
        end
    end

    // An allocated tag was free and a valid free targets a busy tag, so the
    // two never collide.
    always_comb begin
        busy_nxt = busy_q;
        if (alloc_ok) busy_nxt[alloc_tag_c] = 1'b1;
        if (free_ok)  busy_nxt[free_tag]    = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q      <= '0;
            outstanding <= '0;
            err         <= 1'b0;
        end else begin
            busy_q <= busy_nxt;
            case ({alloc_ok, free_ok})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
            if (free && !busy_q[free_tag]) err <= 1'b1;
        end
    end

    // Tag table: plain storage, only meaningful for allocated tags.
    always_ff @(posedge clk) begin
        if (alloc_ok) begin
            id_tab[alloc_tag_c]   <= alloc_id;
            last_tab[alloc_tag_c] <= alloc_last;
        end
    end

    assign lookup_id_c   = id_tab[lookup_tag];
    assign lookup_last_c = last_tab[lookup_tag];

endmodule

// File: rtl/tl_axi_rd_splitter.sv
// Splits AXI4 AR bursts (32 B beats) into PCIe MemRd TLP headers bounded by
// the runtime MRRS and 4 KB address boundaries, one header per cycle.
// Ports: clk/rst_n; config_bdf_i/config_mrrs_i; AR channel ar_*;
// NP header FIFO write port np_hdr_*; tag release cpl_free_*; tag table
// query lookup_*; outstanding_o tag count; err_o sticky invalid-free flag.
module tl_axi_rd_splitter
    import tl_axi_rd_splitter_pkg::*;
#(
    parameter  int unsigned AXI_ID_WIDTH   = 4,
    parameter  int unsigned AXI_ADDR_WIDTH = 64,
    parameter  int unsigned NUM_TAGS       = 64,
    parameter  int unsigned MAX_MRRS_LG2   = 12,
    localparam int unsigned TAG_BIT        = $clog2(NUM_TAGS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [15:0]               config_bdf_i,
    input  logic [2:0]                config_mrrs_i,
    input  logic                      ar_avalid_i,
    output logic                      ar_aready_o,
    input  logic [AXI_ID_WIDTH-1:0]   ar_aid_i,
    input  logic [AXI_ADDR_WIDTH-1:0] ar_aaddr_i,
    input  logic [7:0]                ar_alen_i,
    input  logic                      np_hdr_full_i,
    output logic                      np_hdr_wren_o,
    output logic [HDR_W-1:0]          np_hdr_wdata_o,
    input  logic                      cpl_free_i,
    input  logic [TAG_BIT-1:0]        cpl_free_tag_i,
    input  logic [TAG_BIT-1:0]        lookup_tag_i,
    output logic [AXI_ID_WIDTH-1:0]   lookup_id_o,
    output logic                      lookup_last_o,
    output logic [TAG_BIT:0]          outstanding_o,
    output logic                      err_o
);

    rd_state_e                 state_q;
    rd_state_e                 state_nxt;
    logic [AXI_ADDR_WIDTH-1:0] cur_addr_q;
    logic [CHUNK_W-1:0]        rem_q;
    logic [AXI_ID_WIDTH-1:0]   cur_id_q;

    logic [CHUNK_W-1:0]        mrrs_bytes_c;
    logic [CHUNK_W-1:0]        to_bdy_c;
    logic [CHUNK_W-1:0]        chunk_c;
    logic                      is_last_c;
    logic                      issue_c;
    logic                      free_avail_c;
    logic [TAG_BIT-1:0]        alloc_tag_c;
    logic                      handshake_c;

    // Chunk = min(remaining, MRRS, bytes to next 4 KB boundary).
    always_comb begin
        mrrs_bytes_c = mrrs_decode(config_mrrs_i, MAX_MRRS_LG2);
        to_bdy_c     = 14'd4096 - {2'b00, cur_addr_q[11:0]};
        chunk_c      = rem_q;
        if (mrrs_bytes_c < chunk_c) chunk_c = mrrs_bytes_c;
        if (to_bdy_c < chunk_c)     chunk_c = to_bdy_c;
        is_last_c    = (chunk_c == rem_q);
    end

    assign handshake_c = rst_n && (state_q == ST_IDLE) && ar_avalid_i;
    assign issue_c     = rst_n && (state_q == ST_SPLIT) && !np_hdr_full_i && free_avail_c;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE:  if (handshake_c) state_nxt = ST_SPLIT;
            ST_SPLIT: if (issue_c && is_last_c) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Burst context: latched on AR handshake, advanced per issued chunk.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_addr_q <= '0;
            rem_q      <= '0;
            cur_id_q   <= '0;
        end else if (handshake_c) begin
            cur_addr_q <= ar_aaddr_i;
            rem_q      <= {9'(ar_alen_i) + 9'd1, 5'b00000};
            cur_id_q   <= ar_aid_i;
        end else if (issue_c) begin
            cur_addr_q <= cur_addr_q + AXI_ADDR_WIDTH'(chunk_c);
            rem_q      <= rem_q - chunk_c;
        end
    end

    // Outputs; header data stays valid while stalled.
    always_comb begin
        ar_aready_o    = rst_n && (state_q == ST_IDLE);
        np_hdr_wren_o  = issue_c;
        np_hdr_wdata_o = pack_mem_rd_hdr(64'(cur_addr_q), chunk_c[11:2],
                                         8'(alloc_tag_c), config_bdf_i);
    end

    tl_tag_alloc #(
        .NUM_TAGS (NUM_TAGS),
        .ID_W     (AXI_ID_WIDTH)
    ) u_tag_alloc (
        .clk           (clk),
        .rst_n         (rst_n),
        .alloc         (issue_c),
        .alloc_id      (cur_id_q),
        .alloc_last    (is_last_c),
        .free_avail_c  (free_avail_c),
        .alloc_tag_c   (alloc_tag_c),
        .free          (cpl_free_i),
        .free_tag      (cpl_free_tag_i),
        .lookup_tag    (lookup_tag_i),
        .lookup_id_c   (lookup_id_o),
        .lookup_last_c (lookup_last_o),
        .outstanding   (outstanding_o),
        .err           (err_o)
    );

endmodule
